// File: rtl/sdrc_pkg.sv
// Shared definitions for the SDRAM controller bus-size converter.
//   - sdr_width encodings (SDR_W32 / SDR_W16 / SDR_W8; 2'b11 also means 8-bit)
//   - helpers that turn a width mode plus the physical SDRAM width into the
//     effective beat width, the application/SDRAM ratio and the last lane index
//   - lane-select constants used when indexing lanes of an application word
package sdrc_pkg;

  localparam int APP_WORD_W = 32;
  localparam int APP_BYTES  = APP_WORD_W / 8;

  localparam logic [1:0] SDR_W32 = 2'b00;
  localparam logic [1:0] SDR_W16 = 2'b01;
  localparam logic [1:0] SDR_W8  = 2'b10;

  // Lane sizes in bits for each effective beat width.
  localparam int LANE_BITS_W8  = 8;
  localparam int LANE_BITS_W16 = 16;
  localparam int LANE_BITS_W32 = 32;

  // Width mode that matches the physical bus; used as the reset mode.
  function automatic logic [1:0] mode_of_dw(input int sdr_dw);
    if (sdr_dw >= 32)      return SDR_W32;
    else if (sdr_dw == 16) return SDR_W16;
    else                   return SDR_W8;
  endfunction

  // Effective beat width in bits: the requested width, clamped to the bus.
  function automatic int lane_bits(input logic [1:0] mode, input int sdr_dw);
    int req;
    case (mode)
      SDR_W32: req = LANE_BITS_W32;
      SDR_W16: req = LANE_BITS_W16;
      default: req = LANE_BITS_W8;
    endcase
    return (req > sdr_dw) ? sdr_dw : req;
  endfunction

  // Number of SDRAM beats per application word: 1, 2 or 4.
  function automatic logic [2:0] ratio_of(input logic [1:0] mode, input int sdr_dw);
    return 3'(APP_WORD_W / lane_bits(mode, sdr_dw));
  endfunction

  // Index of the final lane of a word (ratio - 1).
  function automatic logic [1:0] last_lane(input logic [1:0] mode, input int sdr_dw);
    case (ratio_of(mode, sdr_dw))
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/sdrc_rd_pack.sv
// Read packer: collects SDRAM-width read beats into 32-bit application words.
// Ports:
//   clk, reset_n              core clock, asynchronous active-low reset
//   sdr_width                 width mode, captured on x2a_rdstart
//   x2a_rdstart               first beat of a burst (restarts packing at lane 0)
//   x2a_rdok / x2a_rdlast     beat valid / last beat of the burst
//   x2a_rddt                  read beat data (only the low W bits are used)
//   app_rd_data               packed word, holds between completions
//   app_rd_valid              one-cycle pulse, 1 clk after the completing beat
//   app_last_rd               qualifies app_rd_valid: final word of the burst
//   rd_cnt_dbg                current lane counter, for observation
//
// Handshake: there is no back-pressure on either side. A beat is taken on any
// cycle with x2a_rdok=1; a packed word is presented for exactly the one cycle
// app_rd_valid=1 and the application must accept it then.
module sdrc_rd_pack
  import sdrc_pkg::*;
#(
  parameter int SDR_DW = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            sdr_width,
  input  logic                  x2a_rdstart,
  input  logic                  x2a_rdok,
  input  logic                  x2a_rdlast,
  input  logic [SDR_DW-1:0]     x2a_rddt,
  output logic [APP_WORD_W-1:0] app_rd_data,
  output logic                  app_rd_valid,
  output logic                  app_last_rd,
  output logic [1:0]            rd_cnt_dbg
);

  logic [1:0]            rd_mode;
  logic [1:0]            rd_mode_cur;
  logic [1:0]            rd_cnt;
  logic [1:0]            rd_lane;
  logic [1:0]            rd_last_lane;
  logic [APP_WORD_W-1:0] rd_buf;
  logic [APP_WORD_W-1:0] rd_merged;
  int                    rd_bits;
  logic                  rd_done;

  assign rd_cnt_dbg = rd_cnt;

  // A start beat sees an empty buffer and the freshly requested width, so any
  // leftover lane from an earlier burst is dropped rather than merged.
  always_comb begin
    rd_mode_cur  = x2a_rdstart ? sdr_width : rd_mode;
    rd_bits      = lane_bits(rd_mode_cur, SDR_DW);
    rd_last_lane = last_lane(rd_mode_cur, SDR_DW);
    rd_lane      = x2a_rdstart ? 2'd0 : rd_cnt;
    rd_merged    = x2a_rdstart ? '0 : rd_buf;
    for (int i = 0; i < SDR_DW; i++) begin
      if (i < rd_bits) rd_merged[5'(int'(rd_lane) * rd_bits + i)] = x2a_rddt[i];
    end
    rd_done = x2a_rdok & ((rd_lane == rd_last_lane) | x2a_rdlast);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_mode      <= mode_of_dw(SDR_DW);
      rd_cnt       <= 2'd0;
      rd_buf       <= '0;
      app_rd_data  <= '0;
      app_rd_valid <= 1'b0;
      app_last_rd  <= 1'b0;
    end else begin
      app_rd_valid <= rd_done;
      app_last_rd  <= rd_done & x2a_rdlast;
      if (x2a_rdstart) rd_mode <= sdr_width;
      if (rd_done) begin
        // Unwritten lanes of a short final word stay 0 from the cleared buffer.
        rd_cnt      <= 2'd0;
        rd_buf      <= '0;
        app_rd_data <= rd_merged;
      end else if (x2a_rdok) begin
        rd_cnt <= rd_lane + 2'd1;
        rd_buf <= rd_merged;
      end else if (x2a_rdstart) begin
        rd_cnt <= 2'd0;
        rd_buf <= '0;
      end
    end
  end

endmodule

// File: rtl/sdrc_bus_conv.sv
// Application <-> SDRAM bus-size converter.
//   Write path: splits one application word into 1/2/4 SDRAM beats, lane 0
//   (least-significant bits) first. Read path: sdrc_rd_pack packs beats back.
// Ports:
//   clk, reset_n                          core clock, async active-low reset
//   sdr_width                             00=32b 01=16b 10/11=8b, per burst
//   x2a_wrstart/x2a_wrnext/x2a_wrlast     write burst start / beat taken / last
//   a2x_wrdt, a2x_wren_n                  current write beat and byte enables
//   app_wr_data, app_wr_en_n              application word (held until next)
//   app_wr_next, app_last_wr              word consumed / it ended the burst
//   x2a_rdstart/x2a_rdok/x2a_rdlast       read burst start / beat valid / last
//   x2a_rddt                              read beat data
//   app_rd_data/app_rd_valid/app_last_rd  packed read word and qualifiers
//
// Handshake: no back-pressure. x2a_wrnext means the transfer controller took
// the beat shown this cycle; app_wr_next is a same-cycle pulse telling the
// application to present its next word. Read words are single-cycle pulses.
module sdrc_bus_conv
  import sdrc_pkg::*;
#(
  parameter int APP_DW = 32,
  parameter int SDR_DW = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          sdr_width,
  input  logic                x2a_wrstart,
  input  logic                x2a_wrnext,
  input  logic                x2a_wrlast,
  output logic [SDR_DW-1:0]   a2x_wrdt,
  output logic [SDR_DW/8-1:0] a2x_wren_n,
  input  logic [APP_DW-1:0]   app_wr_data,
  input  logic [APP_DW/8-1:0] app_wr_en_n,
  output logic                app_wr_next,
  output logic                app_last_wr,
  input  logic                x2a_rdstart,
  input  logic                x2a_rdok,
  input  logic                x2a_rdlast,
  input  logic [SDR_DW-1:0]   x2a_rddt,
  output logic [APP_DW-1:0]   app_rd_data,
  output logic                app_rd_valid,
  output logic                app_last_rd
);

  logic [1:0] wr_mode;
  logic [1:0] wr_mode_cur;
  logic [1:0] wr_cnt;
  logic [1:0] wr_lane;
  logic [1:0] wr_last_lane;
  logic       wr_wrap;
  int         wr_bits;
  logic [1:0] rd_cnt_dbg;

  // Write lane mux. A start cycle always shows lane 0 using the width being
  // requested now, since wr_mode only picks it up at the clock edge.
  always_comb begin
    wr_mode_cur  = x2a_wrstart ? sdr_width : wr_mode;
    wr_bits      = lane_bits(wr_mode_cur, SDR_DW);
    wr_last_lane = last_lane(wr_mode_cur, SDR_DW);
    wr_lane      = x2a_wrstart ? 2'd0 : wr_cnt;
    wr_wrap      = (wr_lane == wr_last_lane) | x2a_wrlast;
    a2x_wrdt     = '0;
    a2x_wren_n   = '1;
    for (int i = 0; i < SDR_DW; i++) begin
      if (i < wr_bits) a2x_wrdt[i] = app_wr_data[5'(int'(wr_lane) * wr_bits + i)];
    end
    for (int j = 0; j < SDR_DW / 8; j++) begin
      if (j < wr_bits / 8)
        a2x_wren_n[j] = app_wr_en_n[2'(int'(wr_lane) * (wr_bits / 8) + j)];
    end
    app_wr_next = x2a_wrnext & wr_wrap;
    app_last_wr = x2a_wrnext & wr_wrap & x2a_wrlast;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_mode <= mode_of_dw(SDR_DW);
      wr_cnt  <= 2'd0;
    end else begin
      if (x2a_wrstart) wr_mode <= sdr_width;
      // An early x2a_wrlast retires the word; untransmitted lanes are skipped.
      if (x2a_wrnext)       wr_cnt <= wr_wrap ? 2'd0 : wr_lane + 2'd1;
      else if (x2a_wrstart) wr_cnt <= 2'd0;
    end
  end

  sdrc_rd_pack #(
    .SDR_DW(SDR_DW)
  ) u_rd_pack (
    .clk          (clk),
    .reset_n      (reset_n),
    .sdr_width    (sdr_width),
    .x2a_rdstart  (x2a_rdstart),
    .x2a_rdok     (x2a_rdok),
    .x2a_rdlast   (x2a_rdlast),
    .x2a_rddt     (x2a_rddt),
    .app_rd_data  (app_rd_data),
    .app_rd_valid (app_rd_valid),
    .app_last_rd  (app_last_rd),
    .rd_cnt_dbg   (rd_cnt_dbg)
  );

endmodule
